// File: rtl/sdp_ram_pkg.sv
// -----------------------------------------------------------------------------
// sdp_ram_pkg
// Shared types and constants for the parametrised simple dual-port RAM.
//   clr_state_t       : state of the hardware clear engine
//   COLL_READ_FIRST   : same-address read/write returns pre-write data
//   COLL_WRITE_FIRST  : same-address read/write returns merged (new) data
// -----------------------------------------------------------------------------
package sdp_ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam int COLL_READ_FIRST  = 0;
    localparam int COLL_WRITE_FIRST = 1;

endpackage

// File: rtl/sdp_ram_core.sv
// -----------------------------------------------------------------------------
// sdp_ram_core
// Pure byte-enabled storage array with a one-cycle registered read port.
// Ports:
//   clk    : clock, rising edge
//   we     : write strobe
//   be     : byte enables, bit i qualifies wdata[8i+7:8i]
//   waddr  : write address (caller guarantees < DEPTH when we = 1)
//   wdata  : write data
//   re     : read strobe; rdata updates only when re = 1
//   raddr  : read address (caller guarantees < DEPTH when re = 1)
//   rdata  : registered read data (pre-write value on same-address access)
// -----------------------------------------------------------------------------
module sdp_ram_core #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                re,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [DATA_W-1:0]   rdata
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array and its read register have no reset, so the storage
    // maps onto block RAM; contents after power-up are undefined.
    // NOTE: non-blocking assignments make a same-address read in the same
    // cycle observe the pre-write word (natural read-first behaviour).
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sdp_ram_param.sv
// -----------------------------------------------------------------------------
// sdp_ram_param
// Parametrised single-clock simple dual-port RAM used as the DDS waveform and
// sample store. Byte-enabled writes, 1- or 2-cycle read latency, selectable
// read/write collision behaviour and a hardware zero-fill engine.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   wr_en, wr_be, wr_addr, wr_data : write request, byte enables, address, data
//   wr_ready   : 1 = write accepted this cycle; 0 while the clear sweep runs
//   rd_en, rd_addr : read request and address
//   rd_data, rd_valid : read result and its strobe, RD_LAT cycles after rd_en
//   clr_req    : pulse to start zero-filling the whole array
//   clr_busy   : high for exactly DEPTH cycles while the sweep runs
//   addr_err   : sticky flag for any enabled access with address >= DEPTH
// -----------------------------------------------------------------------------
module sdp_ram_param
    import sdp_ram_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int RD_LAT    = 1,
    parameter int COLL_MODE = COLL_READ_FIRST
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                wr_ready,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                addr_err
);

    localparam int NB = DATA_W / 8;
    // One extra bit so the comparison also works when DEPTH is a power of 2.
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic wr_in_range;
    logic rd_in_range;
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_X);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_X);

    // ---------------------------------------------------------------- clear FSM
    clr_state_t        state;
    logic [ADDR_W-1:0] clr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            clr_cnt  <= '0;
            clr_busy <= 1'b0;
            wr_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state    <= CLEAR;
                        clr_cnt  <= '0;
                        clr_busy <= 1'b1;
                        wr_ready <= 1'b0;
                    end
                end
                CLEAR: begin
                    // clr_req is ignored here: a running sweep never restarts.
                    if (clr_cnt == LAST_ADDR) begin
                        state    <= IDLE;
                        clr_cnt  <= '0;
                        clr_busy <= 1'b0;
                        wr_ready <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------- write muxing
    logic              core_we;
    logic [NB-1:0]     core_be;
    logic [ADDR_W-1:0] core_waddr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_re;
    logic [DATA_W-1:0] core_rdata;

    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        core_we    = 1'b0;
        core_be    = '0;
        core_waddr = wr_addr;
        core_wdata = wr_data;
        if (state == CLEAR) begin
            // The sweep owns the write port; user writes are dropped.
            core_we    = 1'b1;
            core_be    = '1;
            core_waddr = clr_cnt;
            core_wdata = '0;
        end else if (wr_en && wr_in_range) begin
            core_we = 1'b1;
            core_be = wr_be;
        end
    end

    assign core_re = rd_en && rd_in_range;

    sdp_ram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk   (clk),
        .we    (core_we),
        .be    (core_be),
        .waddr (core_waddr),
        .wdata (core_wdata),
        .re    (core_re),
        .raddr (rd_addr),
        .rdata (core_rdata)
    );

    // ------------------------------------------- read stage 1 (array register)
    logic              collide;
    logic              rd_v1;
    logic              rd_zero1;   // forces 0: out-of-range read, or nothing read since reset
    logic              byp1;
    logic [NB-1:0]     byp_be1;
    logic [DATA_W-1:0] byp_data1;
    logic [DATA_W-1:0] d1;

    assign collide = core_we && core_re && (core_waddr == rd_addr);

    // The side-band flags only move on a read, so d1 holds its value between
    // reads just like the array register does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1     <= 1'b0;
            rd_zero1  <= 1'b1;
            byp1      <= 1'b0;
            byp_be1   <= '0;
            byp_data1 <= '0;
        end else begin
            rd_v1 <= rd_en;
            if (rd_en) begin
                rd_zero1  <= !rd_in_range;
                byp1      <= (COLL_MODE == COLL_WRITE_FIRST) && collide;
                byp_be1   <= core_be;
                byp_data1 <= core_wdata;
            end
        end
    end

    // Write-first: overlay the enabled bytes of the colliding write onto the
    // pre-write word captured by the array register.
    always_comb begin
        d1 = core_rdata;
        if (byp1) begin
            for (int b = 0; b < NB; b++) begin
                if (byp_be1[b]) begin
                    d1[8*b +: 8] = byp_data1[8*b +: 8];
                end
            end
        end
        if (rd_zero1) begin
            d1 = '0;
        end
    end

    // ------------------------------------------------- optional output stage
    generate
        if (RD_LAT == 1) begin : g_lat1
            assign rd_valid = rd_v1;
            assign rd_data  = d1;
        end else begin : g_lat2
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    rd_valid <= rd_v1;
                    if (rd_v1) begin
                        rd_data <= d1;
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------ sticky error flag
    logic err_set;
    assign err_set = (wr_en && !wr_in_range) || (rd_en && !rd_in_range);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
        end else if (clr_req) begin
            addr_err <= err_set;
        end else if (err_set) begin
            addr_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdp_ram_param.sv
// -----------------------------------------------------------------------------
// tb_sdp_ram_param
// Drives two builds of sdp_ram_param from one stimulus stream:
//   inst 0 : DEPTH=1024, RD_LAT=1, READ_FIRST
//   inst 1 : DEPTH=1000, RD_LAT=2, WRITE_FIRST
// A word-level memory model per build predicts every output cycle by cycle.
// -----------------------------------------------------------------------------
module tb_sdp_ram_param;
    import sdp_ram_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr_en, rd_en, clr_req;
    logic [3:0]  wr_be;
    logic [9:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;

    logic [31:0] rd_data_o  [2];
    logic        rd_valid_o [2];
    logic        clr_busy_o [2];
    logic        wr_ready_o [2];
    logic        addr_err_o [2];

    always #5 clk = ~clk;

    sdp_ram_param #(
        .DATA_W(32), .DEPTH(1024), .RD_LAT(1), .COLL_MODE(COLL_READ_FIRST)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready_o[0]),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_o[0]), .rd_valid(rd_valid_o[0]),
        .clr_req(clr_req), .clr_busy(clr_busy_o[0]), .addr_err(addr_err_o[0])
    );

    sdp_ram_param #(
        .DATA_W(32), .DEPTH(1000), .RD_LAT(2), .COLL_MODE(COLL_WRITE_FIRST)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready_o[1]),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_o[1]), .rd_valid(rd_valid_o[1]),
        .clr_req(clr_req), .clr_busy(clr_busy_o[1]), .addr_err(addr_err_o[1])
    );

    function automatic int dep_of(input int i);
        return (i == 0) ? 1024 : 1000;
    endfunction
    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction
    function automatic bit wf_of(input int i);
        return (i == 0) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // ---------------------------------------------------------------- model
    logic [31:0] mm [2][1024];
    bit          kn [2][1024];      // word content is known to the model
    bit          clearing [2];
    int          clr_idx  [2];
    bit          err_m    [2];
    bit          hv [2][4];         // read result issued at edge n, slot n%4
    bit          hk [2][4];
    logic [31:0] hd [2][4];
    logic [31:0] last_d [2];
    bit          last_k [2];
    int          busy_cnt [2];
    int          cyc    = 0;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input int i,
                         input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] cyc=%0d observed=%h expected=%h", tag, i, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            clearing[i] = 1'b0;
            clr_idx[i]  = 0;
            err_m[i]    = 1'b0;
            last_d[i]   = '0;
            last_k[i]   = 1'b1;
            for (int s = 0; s < 4; s++) hv[i][s] = 1'b0;
        end
    endtask

    task automatic model_step(input int i);
        int          d, ra, wa, slot;
        bit          wr_acc, c_on, ok, nk, ek, eset;
        logic [31:0] old_w, new_w, ew;
        d    = dep_of(i);
        ra   = int'(rd_addr);
        wa   = int'(wr_addr);
        slot = cyc % 4;
        c_on = clearing[i];
        wr_acc = wr_en && !c_on && (wa < d);
        hv[i][slot] = rd_en;
        if (rd_en) begin
            ew = '0;
            ek = 1'b1;
            if (ra < d) begin
                old_w = mm[i][ra];
                ok    = kn[i][ra];
                new_w = old_w;
                nk    = ok;
                if (c_on && clr_idx[i] == ra) begin
                    new_w = '0;
                    nk    = 1'b1;
                end
                if (wr_acc && wa == ra) begin
                    new_w = merge(old_w, wr_data, wr_be);
                    nk    = ok || (wr_be == 4'hF);
                end
                if (wf_of(i)) begin
                    ew = new_w; ek = nk;
                end else begin
                    ew = old_w; ek = ok;
                end
            end
            hd[i][slot] = ew;
            hk[i][slot] = ek;
        end
        eset = (rd_en && ra >= d) || (wr_en && wa >= d);
        if (clr_req) err_m[i] = 1'b0;
        if (eset)    err_m[i] = 1'b1;
        if (c_on) begin
            mm[i][clr_idx[i]] = '0;
            kn[i][clr_idx[i]] = 1'b1;
        end
        if (wr_acc) begin
            mm[i][wa] = merge(mm[i][wa], wr_data, wr_be);
            kn[i][wa] = kn[i][wa] || (wr_be == 4'hF);
        end
        if (c_on) begin
            if (clr_idx[i] == d - 1) clearing[i] = 1'b0;
            else                     clr_idx[i]++;
        end else if (clr_req) begin
            clearing[i] = 1'b1;
            clr_idx[i]  = 0;
        end
    endtask

    task automatic check_outputs();
        int s;
        for (int i = 0; i < 2; i++) begin
            s = ((cyc - (lat_of(i) - 1)) % 4 + 4) % 4;
            check("rd_valid", i, 32'(rd_valid_o[i]), 32'(hv[i][s]));
            if (hv[i][s]) begin
                if (hk[i][s]) check("rd_data", i, rd_data_o[i], hd[i][s]);
                last_d[i] = hd[i][s];
                last_k[i] = hk[i][s];
            end else if (last_k[i]) begin
                check("rd_data_hold", i, rd_data_o[i], last_d[i]);
            end
            check("clr_busy", i, 32'(clr_busy_o[i]), 32'(clearing[i]));
            check("wr_ready", i, 32'(wr_ready_o[i]), 32'(!clearing[i]));
            check("addr_err", i, 32'(addr_err_o[i]), 32'(err_m[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!rst_n) model_reset();
        else for (int i = 0; i < 2; i++) model_step(i);
        #1;
        for (int i = 0; i < 2; i++) if (clr_busy_o[i]) busy_cnt[i]++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = 10'(a); wr_data = d; wr_be = be;
    endtask

    task automatic rd(input int a);
        rd_en = 1'b1; rd_addr = 10'(a);
    endtask

    initial begin
        wr_en = 0; rd_en = 0; clr_req = 0; wr_be = 0;
        wr_addr = 0; rd_addr = 0; wr_data = 0;

        // Reset values.
        #1 rst_n = 1'b0;
        #1 model_reset();
        check_outputs();
        tick(); tick();
        rst_n = 1'b1;
        idle(2);

        // T1: addr i = i*i, then back-to-back reads.
        for (int i = 0; i < 6; i++) begin wr(i, 32'(i * i), 4'hF); tick(); end
        wr_en = 1'b0;
        for (int i = 0; i < 6; i++) begin rd(i); tick(); end
        idle(3);

        // T2: same-cycle write/read of addr 3, then a plain read.
        wr(3, 32'h0000_000D, 4'hF); rd(3); tick();
        wr_en = 1'b0; rd(3); tick();
        idle(3);

        // T3: byte-enabled partial write.
        wr(7, 32'hAABB_CCDD, 4'hF); tick();
        wr(7, 32'h1122_3344, 4'b0101); tick();
        wr_en = 1'b0; rd(7); tick();
        idle(3);

        // Known contents for low addresses and the top word.
        for (int i = 0; i < 32; i++) begin wr(i, $urandom, 4'hF); tick(); end
        wr(1023, $urandom, 4'hF); tick();
        idle(2);

        // T4: continuous reads of 0..9.
        for (int i = 0; i < 10; i++) begin rd(i); tick(); end
        idle(4);

        // Randomized traffic with forced collisions and occasional high addresses.
        for (int k = 0; k < 300; k++) begin
            wr_en   = 1'($urandom_range(0, 1));
            rd_en   = 1'($urandom_range(0, 1));
            wr_be   = 4'($urandom);
            wr_data = $urandom;
            wr_addr = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023))
                                                  : 10'($urandom_range(0, 15));
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr
                    : ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023))
                                                  : 10'($urandom_range(0, 15));
            tick();
        end
        idle(3);

        // T5: fill, clear sweep with dropped writes, live reads and an ignored re-request.
        for (int i = 0; i < 6; i++) begin wr(i, 32'(i + 10), 4'hF); tick(); end
        wr_en = 1'b0;
        busy_cnt[0] = 0; busy_cnt[1] = 0;
        clr_req = 1'b1; tick();
        for (int k = 0; k < 1030; k++) begin
            clr_req = (k == 500);
            wr_en   = 1'($urandom_range(0, 1));
            wr(int'($urandom_range(0, 5)), $urandom, 4'hF);
            wr_en   = 1'($urandom_range(0, 1));
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = 10'($urandom_range(0, 31));
            tick();
        end
        idle(2);
        for (int i = 0; i < 2; i++) check("clr_busy_cycles", i, 32'(busy_cnt[i]), 32'(dep_of(i)));
        for (int i = 0; i < 6; i++) begin rd(i); tick(); end
        idle(3);

        // T6: reset in the middle of a sweep with reads in flight.
        clr_req = 1'b1; tick();
        clr_req = 1'b0;
        for (int k = 0; k < 100; k++) begin rd(int'($urandom_range(0, 31))); tick(); end
        rst_n = 1'b0;
        #1 model_reset();
        check_outputs();
        rd_en = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        idle(4);
        wr(1023, 32'd5, 4'hF); tick();
        wr_en = 1'b0; rd(1023); tick();
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
